mc_mem_responder: RTL
=====================

// Module: mc_mem_responder
// PURPOSE
//  Memory-side responder for the multicycle CPU memory port (adr/MemWrite/writedata/readdata).
//  Decodes each access to word RAM or to an MMIO page holding LED, switch and timer registers.
//  Sits between the CPU and board I/O in the SoC top level.
//  Reads are combinational, so the CPU's IR and data register latch readdata in the same
//  cycle. Writes commit on the clk rising edge.
// PARAMETERS
//  DEPTH      1024          RAM size in 32-bit words; 4*DEPTH must be <= MMIO_BASE
//  MMIO_BASE  32'h00007F00  byte base address of the MMIO page (32-byte page, 8 words)
//  INIT_FILE  ""            $readmemh image for RAM; empty string = no preload
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   reset, synchronous, active-low
//  MemWrite   in   1   write strobe from CPU, sampled at clk rising edge
//  adr        in   32  byte address; adr[1:0] ignored (word access only)
//  writedata  in   32  write data
//  readdata   out  32  read data, combinational from adr
//  sw         in   16  board switches, asynchronous to clk
//  led        out  16  LED register
//  timer_irq  out  1   equals TCTRL.flag
//  bus_err    out  1   sticky unmapped-access flag
// BEHAVIOUR
//  Address map (word index w = adr[31:2]):
//   RAM    : adr < 4*DEPTH. Read mem[w]. Write mem[w] <= writedata.
//   +0x00  LED   RW. Bits[15:0]; upper bits read 0.
//   +0x04  SW    RO. Twice-synchronised sw; 2-cycle latency from a pin change. Writes ignored.
//   +0x08  TCNT  RW. 32-bit timer count.
//   +0x0C  TCMP  RW. 32-bit compare value.
//   +0x10  TCTRL RW. bit0 en, bit1 autoreload, bit2 flag (write 1 clears); bits[31:3] read 0.
//   Other  : any other address, including MMIO offsets +0x14..+0x1C, reads 0 and ignores writes.
//            A write to an unmapped address sets bus_err (sticky, cleared only by reset).
//            A read of an unmapped address leaves bus_err unchanged.
//  Reset (rst==0 at a clk edge) sets: led=0, TCNT=0, TCMP=32'hFFFFFFFF, TCTRL=0, bus_err=0,
//   sync flops=0. timer_irq=0 follows from TCTRL.
//  RAM contents are not reset. Reset mid-count stops the timer and clears it immediately.
//  Timer, evaluated each clk edge, in priority order:
//   1. CPU write to TCNT: TCNT <= writedata. Overrides the increment and the match that cycle.
//   2. Else if en && TCNT==TCMP: flag <= 1.
//      If autoreload: TCNT <= 0, en stays 1. Otherwise en <= 0 and TCNT holds.
//   3. Else if en: TCNT <= TCNT+1. Wraps 32'hFFFFFFFF -> 0 without setting flag.
//  TCTRL write: en and autoreload take writedata[1:0]. flag is cleared if writedata[2]==1.
//   If a match occurs in the same cycle, set wins and flag stays 1.
//   The match evaluation uses the pre-write en.
//  TCMP write in the cycle TCNT equals the old TCMP: the match uses the old TCMP.
//  Each write is a single-cycle effect. A held MemWrite re-writes every cycle (idempotent for RAM).
// CONFIGURATION
//  MMIO_TIMER_EN defined:
//   - TCNT, TCMP and TCTRL are implemented as above.
//   - timer_irq is live.
//  MMIO_TIMER_EN undefined:
//   - +0x08..+0x10 are unmapped: read 0, writes set bus_err.
//   - No timer flops are instantiated.
//   - timer_irq is tied to 0.
// TESTING
//  - RAM: MemWrite=1, adr=0x10, writedata=0xDEADBEEF, one clk.
//    Then MemWrite=0, adr=0x13 -> readdata=0xDEADBEEF the same cycle, with no clock edge needed.
//  - LED/SW: write 0x0001A5A5 to 0x7F00 -> led=0xA5A5, read of 0x7F00=0x0000A5A5.
//    Set sw=0x1234 -> read of 0x7F04 is 0x1234 from the 2nd edge after the change.
//  - Timer one-shot: TCMP=5, TCNT=0, TCTRL=1 -> timer_irq=1 six edges after the TCTRL write.
//    Then TCNT holds 5 and en=0. Writing 0x4 to TCTRL clears timer_irq.
//  - Autoreload and collision: TCMP=2, TCTRL=3 -> TCNT sequence 0,1,2,0,1,2.
//    A W1C of flag in a match cycle leaves flag=1.
//    A write of TCNT=100 in a match cycle yields TCNT=100 and no flag set.
//  - Unmapped and reset: write to 0x8000 -> bus_err=1, and RAM/LED are unchanged.
//    A read of 0x7F18 returns 0. rst=0 for one edge mid-count -> all registers at reset values.
//  - Config: build without MMIO_TIMER_EN, write to 0x7F08 -> bus_err=1, read=0, timer_irq=0.

Source files
------------

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: word RAM plus an MMIO page (LED, SW, timer) on the multicycle CPU port.
// Define MMIO_TIMER_EN to build the TCNT/TCMP/TCTRL timer; otherwise those slots are unmapped.
module mc_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0000_7F00,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] ram_idx;
  logic [2:0]    off;
  logic          is_ram;
  logic          is_mmio;
  logic          sel_led;
  logic          sel_sw;
  logic          timer_map;
  logic          mapped;
  logic [15:0]   sw_s1;
  logic [15:0]   sw_s2;

  assign ram_idx = adr[AW+1:2];
  assign off     = adr[4:2];
  assign is_ram  = adr < RAM_BYTES;
  assign is_mmio = adr[31:5] == MMIO_BASE[31:5];
  assign sel_led = is_mmio && off == 3'd0;
  assign sel_sw  = is_mmio && off == 3'd1;
  assign mapped  = is_ram | sel_led | sel_sw | timer_map;

  always_ff @(posedge clk) begin
    if (MemWrite && is_ram)
      mem[ram_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led     <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      bus_err <= 1'b0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (MemWrite && sel_led)
        led <= writedata[15:0];
      if (MemWrite && !mapped)
        bus_err <= 1'b1;
    end
  end

`ifdef MMIO_TIMER_EN
  logic        sel_tcnt;
  logic        sel_tcmp;
  logic        sel_tctrl;
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic [31:0] tcnt_d;
  logic [31:0] tcmp_d;
  logic        en;
  logic        ar;
  logic        flag;
  logic        en_d;
  logic        ar_d;
  logic        flag_d;
  logic        hit;

  assign sel_tcnt  = is_mmio && off == 3'd2;
  assign sel_tcmp  = is_mmio && off == 3'd3;
  assign sel_tctrl = is_mmio && off == 3'd4;
  assign timer_map = sel_tcnt | sel_tcmp | sel_tctrl;
  assign timer_irq = flag;

  // Match uses pre-write en/TCMP; a TCNT write suppresses it entirely.
  always_comb begin
    hit    = en && (tcnt == tcmp) && !(MemWrite && sel_tcnt);
    tcnt_d = tcnt;
    tcmp_d = tcmp;
    en_d   = en;
    ar_d   = ar;
    flag_d = flag;
    if (MemWrite && sel_tcnt)
      tcnt_d = writedata;
    else if (hit) begin
      if (ar) tcnt_d = '0;
      else    en_d   = 1'b0;
    end else if (en)
      tcnt_d = tcnt + 32'd1;
    if (MemWrite && sel_tcmp)
      tcmp_d = writedata;
    if (MemWrite && sel_tctrl) begin
      en_d = writedata[0];
      ar_d = writedata[1];
      if (writedata[2]) flag_d = 1'b0;
    end
    if (hit)
      flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt <= '0;
      tcmp <= '1;
      en   <= 1'b0;
      ar   <= 1'b0;
      flag <= 1'b0;
    end else begin
      tcnt <= tcnt_d;
      tcmp <= tcmp_d;
      en   <= en_d;
      ar   <= ar_d;
      flag <= flag_d;
    end
  end
`else
  assign timer_map = 1'b0;
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      is_ram:    readdata = mem[ram_idx];
      sel_led:   readdata = {16'h0, led};
      sel_sw:    readdata = {16'h0, sw_s2};
`ifdef MMIO_TIMER_EN
      sel_tcnt:  readdata = tcnt;
      sel_tcmp:  readdata = tcmp;
      sel_tctrl: readdata = {29'h0, flag, ar, en};
`endif
      default:   readdata = '0;
    endcase
  end

endmodule
